// File: rtl/seg_display_driver.sv
// Eight-digit multiplexed common-anode seven-segment driver: sequential double-dabble
// binary-to-BCD conversion, leading-zero blanking, a mode glyph and a blinking edit cursor.
module seg_display_driver #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] display_value,
  input  logic [3:0]  display_mode,
  input  logic [2:0]  cursor,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  an,
  output logic        busy
);

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  localparam logic [19:0] VALUE_MAX = 20'd999999;
  localparam logic [4:0]  LAST_ITER = 5'd19;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [19:0]       last_val_q, last_val_d;
  logic [43:0]       work_q, work_d;
  logic [43:0]       work_adj;
  logic [4:0]        iter_q, iter_d;
  logic [23:0]       bcd_disp_q, bcd_disp_d;

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic               blink_ph_q, blink_ph_d;

  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic [7:0] an_q, an_d;

  logic [7:0] lz_blank;
  logic [3:0] cur_nib;
  logic       cursor_en;
  logic       cur_hit;

  function automatic logic [6:0] digit_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  function automatic logic [6:0] mode_glyph(input logic [3:0] mode);
    logic [6:0] g;
    case (mode)
      4'd0:    g = 7'b0001110;  // F
      4'd1:    g = 7'b0001100;  // P
      4'd2:    g = 7'b0100001;  // d
      4'd3:    g = 7'b0101111;  // r
      4'd4:    g = 7'b0010010;  // S
      4'd5:    g = 7'b0001001;  // H
      4'd6:    g = 7'b1000110;  // C
      default: g = 7'b0111111;  // '-'
    endcase
    return g;
  endfunction

  // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
  always_comb begin
    work_adj = work_q;
    for (int k = 0; k < 6; k++) begin
      if (work_q[20 + 4*k +: 4] >= 4'd5) begin
        work_adj[20 + 4*k +: 4] = work_q[20 + 4*k +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_val_d = last_val_q;
    work_d     = work_q;
    iter_d     = iter_q;
    bcd_disp_d = bcd_disp_q;
    case (state_q)
      ST_IDLE: begin
        if (display_value != last_val_q) begin
          last_val_d = display_value;
          work_d     = {24'd0, (display_value > VALUE_MAX) ? VALUE_MAX : display_value};
          iter_d     = 5'd0;
          state_d    = ST_CONV;
        end
      end
      ST_CONV: begin
        work_d = {work_adj[42:0], 1'b0};
        iter_d = iter_q + 5'd1;
        if (iter_q == LAST_ITER) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        // All six nibbles land together so the scan never shows a half-updated value.
        bcd_disp_d = work_q[43:20];
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_val_q <= 20'd0;
      work_q     <= 44'd0;
      iter_q     <= 5'd0;
      bcd_disp_q <= 24'd0;
    end else begin
      state_q    <= state_d;
      last_val_q <= last_val_d;
      work_q     <= work_d;
      iter_q     <= iter_d;
      bcd_disp_q <= bcd_disp_d;
    end
  end

  assign busy = (state_q != ST_IDLE);

  always_comb begin
    scan_cnt_d  = scan_cnt_q + SCAN_W'(1);
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    blink_ph_d  = blink_ph_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 3'd1;
    end
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q  <= '0;
      idx_q       <= 3'd0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b1;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
    end
  end

  // lz_blank[k]: nibbles k..5 are all zero; digit 0 and digits 6/7 never use it.
  always_comb begin
    lz_blank    = 8'd0;
    lz_blank[5] = (bcd_disp_q[23:20] == 4'd0);
    for (int k = 4; k >= 1; k--) begin
      lz_blank[k] = lz_blank[k+1] && (bcd_disp_q[4*k +: 4] == 4'd0);
    end
  end

  always_comb begin
    case (idx_q)
      3'd0:    cur_nib = bcd_disp_q[3:0];
      3'd1:    cur_nib = bcd_disp_q[7:4];
      3'd2:    cur_nib = bcd_disp_q[11:8];
      3'd3:    cur_nib = bcd_disp_q[15:12];
      3'd4:    cur_nib = bcd_disp_q[19:16];
      3'd5:    cur_nib = bcd_disp_q[23:20];
      default: cur_nib = 4'd0;
    endcase
  end

  assign cursor_en = (display_mode < 4'd6) && (cursor < 3'd3);
  assign cur_hit   = cursor_en && (idx_q == cursor);

  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    an_d  = ~(8'd1 << idx_q);
    if (idx_q == 3'd7) begin
      seg_d = mode_glyph(display_mode);
    end else if (idx_q != 3'd6) begin
      if (lz_blank[idx_q] && !cur_hit) begin
        seg_d = SEG_BLANK;
      end else begin
        seg_d = digit_glyph(cur_nib);
      end
    end
    if (cur_hit) begin
      dp_d = 1'b0;
      if (!blink_ph_q) begin
        seg_d = SEG_BLANK;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= SEG_ZERO;
      dp_q  <= 1'b1;
      an_q  <= 8'b1111_1110;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Scoreboard bench for seg_display_driver: directed values, modes and cursor settings with
// hand-computed digit glyphs and busy-pulse lengths checked by an independent monitor.
module tb_seg_display_driver;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 64;

  localparam logic [6:0] G_0  = 7'b1000000;
  localparam logic [6:0] G_1  = 7'b1111001;
  localparam logic [6:0] G_5  = 7'b0010010;
  localparam logic [6:0] G_7  = 7'b1111000;
  localparam logic [6:0] G_9  = 7'b0010000;
  localparam logic [6:0] G_BL = 7'b1111111;
  localparam logic [6:0] G_F  = 7'b0001110;
  localparam logic [6:0] G_H  = 7'b0001001;
  localparam logic [6:0] G_C  = 7'b1000110;
  localparam logic [6:0] G_M  = 7'b0111111;

  logic        clk;
  logic        rst;
  logic [19:0] display_value;
  logic [3:0]  display_mode;
  logic [2:0]  cursor;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // {an, seg, dp} expected for one displayed digit; busy pulse lengths in cycles.
  logic [15:0] exp_q[$];
  logic [7:0]  busy_q[$];

  int   pulses   = 0;
  int   busy_len = 0;
  int   low_len  = 0;
  int   last_gap = 0;
  logic busy_prev = 1'b0;

  seg_display_driver #(
    .SCAN_DIV (SCAN_DIV),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .display_value(display_value),
    .display_mode (display_mode),
    .cursor       (cursor),
    .seg          (seg),
    .dp           (dp),
    .an           (an),
    .busy         (busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      logic [15:0] e;
      int d;
      n_chk++;
      if ($countones(~an) != 1) begin
        n_fail++;
        $display("FAIL an_onehot: an=%b, required exactly one low bit", an);
      end
      if (exp_q.size() != 0 && an == exp_q[0][15:8]) begin
        e = exp_q.pop_front();
        d = 0;
        for (int i = 0; i < 8; i++) if (!an[i]) d = i;
        n_chk++;
        if ({seg, dp} !== e[7:0]) begin
          n_fail++;
          $display("FAIL digit%0d: seg=%b dp=%b, expected seg=%b dp=%b",
                   d, seg, dp, e[7:1], e[0]);
        end
      end
      if (busy) begin
        if (!busy_prev) begin
          pulses++;
          last_gap = low_len;
        end
        busy_len++;
        low_len = 0;
      end else begin
        if (busy_prev) begin
          n_chk++;
          if (busy_q.size() == 0) begin
            n_fail++;
            $display("FAIL busy_pulse: unexpected pulse of %0d cycles", busy_len);
          end else begin
            logic [7:0] el;
            el = busy_q.pop_front();
            if (busy_len != int'(el)) begin
              n_fail++;
              $display("FAIL busy_len: got %0d cycles, expected %0d", busy_len, el);
            end
          end
          busy_len = 0;
        end
        low_len++;
      end
      busy_prev = busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_value(input logic [19:0] v);
    @(negedge clk);
    display_value = v;
  endtask

  task automatic push_digit(input int d, input logic [6:0] s, input logic p);
    logic [7:0] a;
    a = ~(8'd1 << d);
    exp_q.push_back({a, s, p});
  endtask

  task automatic push_scan(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                           input logic [6:0] s3, input logic [6:0] s4, input logic [6:0] s5,
                           input logic [6:0] s6, input logic [6:0] s7);
    push_digit(0, s0, 1'b1);
    push_digit(1, s1, 1'b1);
    push_digit(2, s2, 1'b1);
    push_digit(3, s3, 1'b1);
    push_digit(4, s4, 1'b1);
    push_digit(5, s5, 1'b1);
    push_digit(6, s6, 1'b1);
    push_digit(7, s7, 1'b1);
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || busy_q.size() != 0) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    n_chk++;
    if (guard >= 300) begin
      n_fail++;
      $display("FAIL %s: timeout with %0d digit and %0d busy expectations left",
               name, exp_q.size(), busy_q.size());
      exp_q.delete();
      busy_q.delete();
    end
  endtask

  // Wait until the displayed blink phase equals ph with enough of the half-period left
  // for a full scan; outputs lag the blink phase by one cycle, hence cyc-1.
  task automatic wait_phase(input int ph);
    int guard;
    int p;
    int cur;
    guard = 0;
    forever begin
      @(negedge clk);
      guard++;
      p   = (cyc - 1) % BLINK_DIV;
      cur = 1 - (((cyc - 1) / BLINK_DIV) % 2);
      if ((p <= 20 && cur == ph) || guard >= 300) break;
    end
    n_chk++;
    if (guard >= 300) begin
      n_fail++;
      $display("FAIL wait_phase: blink phase %0d window not reached", ph);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p0;
    rst           = 1'b1;
    display_value = 20'd0;
    display_mode  = 4'd0;
    cursor        = 3'd7;
    repeat (3) @(negedge clk);
    check("reset_an",   32'(an),   32'(8'b1111_1110));
    check("reset_seg",  32'(seg),  32'(7'b1000000));
    check("reset_dp",   32'(dp),   32'(1'b1));
    check("reset_busy", 32'(busy), 32'(1'b0));
    rst = 1'b0;

    repeat (40) @(negedge clk);
    check("no_conv_after_reset", 32'(pulses), 32'd0);
    push_scan(G_0, G_BL, G_BL, G_BL, G_BL, G_BL, G_BL, G_F);
    drain("reset_scan");

    busy_q.push_back(8'd21);
    set_value(20'd100);
    drain("value100_conv");
    push_scan(G_0, G_0, G_1, G_BL, G_BL, G_BL, G_BL, G_F);
    drain("value100_scan");

    busy_q.push_back(8'd21);
    set_value(20'd1048575);
    drain("clamp_conv");
    push_scan(G_9, G_9, G_9, G_9, G_9, G_9, G_BL, G_F);
    drain("clamp_scan");

    busy_q.push_back(8'd21);
    busy_q.push_back(8'd21);
    set_value(20'd123456);
    repeat (10) @(negedge clk);
    display_value = 20'd5;
    drain("midchange_conv");
    check("midchange_gap", 32'(last_gap), 32'd1);
    check("midchange_pulses", 32'(pulses), 32'd4);
    push_scan(G_5, G_BL, G_BL, G_BL, G_BL, G_BL, G_BL, G_F);
    drain("midchange_scan");

    busy_q.push_back(8'd21);
    @(negedge clk);
    display_mode = 4'd5;
    cursor       = 3'd2;
    set_value(20'd7);
    drain("blink_conv");
    p0 = pulses;
    set_value(20'd7);
    repeat (30) @(negedge clk);
    check("unchanged_no_conv", 32'(pulses), 32'(p0));
    wait_phase(1);
    push_digit(2, G_0, 1'b0);
    drain("blink_on");
    wait_phase(0);
    push_digit(2, G_BL, 1'b0);
    drain("blink_off");
    push_digit(7, G_H, 1'b1);
    push_digit(0, G_7, 1'b1);
    push_digit(1, G_BL, 1'b1);
    drain("blink_other_digits");

    @(negedge clk);
    display_mode = 4'd6;
    cursor       = 3'd1;
    repeat (2) @(negedge clk);
    push_scan(G_7, G_BL, G_BL, G_BL, G_BL, G_BL, G_BL, G_C);
    push_scan(G_7, G_BL, G_BL, G_BL, G_BL, G_BL, G_BL, G_C);
    push_scan(G_7, G_BL, G_BL, G_BL, G_BL, G_BL, G_BL, G_C);
    drain("mode6_scan");

    @(negedge clk);
    display_mode = 4'd9;
    cursor       = 3'd7;
    repeat (2) @(negedge clk);
    push_digit(7, G_M, 1'b1);
    drain("mode9_glyph");

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_display_driver.md
# seg_display_driver

Drives the board's 8-digit multiplexed common-anode seven-segment display from the editor's `display_value`, `display_mode` and `cursor_out` signals.
- Converts the 20-bit binary value to six BCD digits with a sequential double-dabble engine.
- Scans the digits at a fixed rate and shows a mode glyph.
- Blinks the digit currently selected for editing.
- Sits between the configuration/input block and the board pins.

## Interface
Parameters:
- `SCAN_DIV`, 100000, clk cycles each digit stays enabled (≥2)
- `BLINK_DIV`, 25000000, clk cycles per blink half-period (≥2)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-high
- `display_value`  in  20  binary value to show
- `display_mode`  in  4  mode code selecting the glyph on digit 7
- `cursor`  in  3  edited digit index (0–2); values 3–7 mean no cursor
- `seg`  out  7  segments, active-low; bit order {g,f,e,d,c,b,a}
- `dp`  out  1  decimal point, active-low
- `an`  out  8  digit enables, active-low, one-hot; bit i enables digit i (digit 0 is rightmost)
- `busy`  out  1  high while a BCD conversion is in progress

## Operation
Conversion FSM, states IDLE → CONV → COMMIT → IDLE:
- **IDLE**
  - If `display_value` differs from `last_val`, capture it (clamping values above 999999 to 999999), load `last_val` with the raw input, and go to CONV.
  - Otherwise stay in IDLE.
- **CONV**
  - Runs exactly 20 shift iterations, MSB first, one per cycle.
  - Each iteration first adds 3 to every BCD nibble ≥5, then shifts.
  - The working register is 24 BCD bits plus 20 binary bits.
- **COMMIT**
  - Copies the six BCD nibbles into the display register `bcd_disp` in one cycle, so there is never a partially updated display.
- A value change during CONV or COMMIT does not disturb the running conversion. It is detected in the following IDLE cycle.
- `busy` is high in CONV and COMMIT.

Digit content:
- **Digits 0–5:** `bcd_disp` nibbles 0–5.
  - Leading-zero blanking: digit k (1–5) is blank when nibbles k..5 are all zero.
  - Digit 0 is never blanked.
  - In modes 0–5, digit `cursor` (if <3) is never blanked by leading-zero rules.
- **Digit 6:** always blank.
- **Digit 7:** glyph selected by mode: 0 F, 1 P, 2 d, 3 r, 4 S, 5 H, 6 C, 7–15 '-'.
- **Digit codes:** 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- **Other codes:** blank=1111111, F=0001110, P=0001100, d=0100001, r=0101111, S=0010010, H=0001001, C=1000110, '-'=0111111.

Cursor, applies in modes 0–5 with `cursor` <3:
- `dp` is lit steadily on digit `cursor`.
- That digit's segments are forced blank while `blink_ph`=0.
- In all other cases, `dp` is off.
- Mode and cursor are used live, not through the conversion pipeline.

Scanning:
- `scan_cnt` counts 0..SCAN_DIV-1.
- On wrap, the digit index `idx` increments 0..7 and wraps 7→0.
- `blink_cnt` counts 0..BLINK_DIV-1 and toggles `blink_ph` on wrap.

## Timing
- Reset values:
  - Conversion: state IDLE, `busy`=0, `last_val`=0, `bcd_disp`=0.
  - Counters: `scan_cnt`=0, `idx`=0, `blink_cnt`=0, `blink_ph`=1 (visible).
  - Outputs: `an`=11111110, `seg`=1000000, `dp`=1.
- A value change seen in IDLE at edge N:
  - `busy` rises after edge N.
  - CONV covers 20 cycles.
  - COMMIT is the 21st cycle.
  - `bcd_disp` and IDLE are valid after edge N+21; `busy` falls there.
  - The earliest next capture is edge N+22.
- Unchanged input: no conversion, and `busy` stays 0.
- `seg`, `dp` and `an` are registered from `idx`, `bcd_disp`, mode, cursor and `blink_ph`, so they lag those by one cycle. `an` is always exactly one-hot low, including during reset release.
- Reset asserted mid-conversion aborts immediately to reset values. After release, the FSM re-converts if `display_value` ≠0.

## Test plan
All tests use SCAN_DIV=4 and BLINK_DIV=64.
- **Reset:** assert `rst` with `display_value`=0 → `an`=11111110, `seg`=1000000, `dp`=1, `busy`=0. After release, `busy` never rises.
- **Value 100:** `display_value`=100, mode 0, cursor 7 → `busy` high for exactly 21 cycles. Then one full scan shows:
  - digit0=1000000, digit1=1000000, digit2=1111001;
  - digits 3–6 = 1111111;
  - digit7 = 0001110 (F).
- **Clamp:** `display_value`=1048575 → digits 5..0 all show 9 (0010000).
- **Change mid-conversion:** value 123456, then change to 5 at cycle 10 of CONV → 123456 is committed first. A second conversion starts in the following IDLE cycle and the final digits are 0=0010010 with digits 1–5 blank.
- **Cursor blink:** `display_value`=7, mode 5, cursor 2:
  - digit2 shows 1000000 with `dp`=0 while `blink_ph`=1;
  - digit2 shows 1111111 with `dp`=0 while `blink_ph`=0;
  - digit7 = 0001001 (H).
- **Mode 6 and mode 9:** mode 6 with cursor 1 → no blink and `dp`=1 on every digit, digit7=1000110. Mode 9 → digit7=0111111.
